// File: rtl/bias_stream_sched.sv
// Bias ROM sequencer: streams MEM_SIZE coefficients N_REPEAT times into an ap_fifo
// behind a 2-entry skid buffer, launched and completed via an ap_ctrl_hs-style handshake.
module bias_stream_sched #(
    parameter int MEM_SIZE   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int N_REPEAT   = 1,
    localparam int ADDR_W    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
    localparam int TOTAL     = MEM_SIZE * N_REPEAT,
    localparam int CNT_W     = $clog2(TOTAL + 1)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic [ADDR_W-1:0]     rom_address,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] output_V_din,
    input  logic                  output_V_full_n,
    output logic                  output_V_write
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state, next_state;
    logic [1:0]            occ;
    logic                  infl;
    logic [DATA_WIDTH-1:0] buf_head, buf_tail;
    logic [CNT_W-1:0]      reads_left, writes_left;
    logic                  pop;
    logic [2:0]            level;

    always_comb begin
        pop        = (occ != 2'd0) && output_V_full_n;
        // Slots that will be occupied next cycle if no new read is issued now.
        level      = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};
        rom_ce     = (state == S_RUN) && (reads_left != '0) && (level < 3'd2);
        next_state = state;
        case (state)
            S_IDLE:  if (ap_start) next_state = S_RUN;
            S_RUN:   if (pop && (writes_left == CNT_W'(1))) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign ap_idle        = (state == S_IDLE);
    assign ap_done        = (state == S_DONE);
    assign ap_ready       = ap_done;
    assign output_V_write = pop;
    assign output_V_din   = buf_head;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= S_IDLE;
            rom_address <= '0;
            occ         <= 2'd0;
            infl        <= 1'b0;
            buf_head    <= '0;
            buf_tail    <= '0;
            reads_left  <= '0;
            writes_left <= '0;
        end else begin
            state <= next_state;
            infl  <= rom_ce;
            if ((state == S_IDLE) && ap_start) begin
                reads_left  <= CNT_W'(TOTAL);
                writes_left <= CNT_W'(TOTAL);
                rom_address <= '0;
            end
            if (rom_ce) begin
                reads_left <= reads_left - CNT_W'(1);
                if (rom_address == ADDR_W'(MEM_SIZE - 1))
                    rom_address <= '0;
                else
                    rom_address <= rom_address + ADDR_W'(1);
            end
            if (pop)
                writes_left <= writes_left - CNT_W'(1);
            // infl doubles as the push strobe: rom_q is valid one cycle after rom_ce.
            case ({infl, pop})
                2'b10: begin
                    if (occ == 2'd0) buf_head <= rom_q;
                    else             buf_tail <= rom_q;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    occ      <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        buf_head <= buf_tail;
                        buf_tail <= rom_q;
                    end else begin
                        buf_head <= rom_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bias_stream_sched.sv
// Directed bench for bias_stream_sched: three instances (4x2, 4x1, 1x3) share control
// inputs; each scenario task checks one instance cycle by cycle against hand-derived timing.
module tb_bias_stream_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, full_n;
    int   errors = 0;
    int   checks = 0;

    logic        a_idle, a_done, a_ready, a_ce, a_write;
    logic [1:0]  a_addr;
    logic [15:0] a_q, a_din;
    logic        b_idle, b_done, b_ready, b_ce, b_write;
    logic [1:0]  b_addr;
    logic [15:0] b_q, b_din;
    logic        c_idle, c_done, c_ready, c_ce, c_write;
    logic [0:0]  c_addr;
    logic [15:0] c_q, c_din;

    logic [15:0] exp4 [4];
    initial begin
        exp4[0] = 16'd10; exp4[1] = 16'd20; exp4[2] = 16'd30; exp4[3] = 16'd40;
    end

    bias_stream_sched #(.MEM_SIZE(4), .DATA_WIDTH(16), .N_REPEAT(2)) dut_a (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_idle(a_idle), .ap_done(a_done),
        .ap_ready(a_ready), .rom_address(a_addr), .rom_ce(a_ce), .rom_q(a_q),
        .output_V_din(a_din), .output_V_full_n(full_n), .output_V_write(a_write));

    bias_stream_sched #(.MEM_SIZE(4), .DATA_WIDTH(16), .N_REPEAT(1)) dut_b (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_idle(b_idle), .ap_done(b_done),
        .ap_ready(b_ready), .rom_address(b_addr), .rom_ce(b_ce), .rom_q(b_q),
        .output_V_din(b_din), .output_V_full_n(full_n), .output_V_write(b_write));

    bias_stream_sched #(.MEM_SIZE(1), .DATA_WIDTH(16), .N_REPEAT(3)) dut_c (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_idle(c_idle), .ap_done(c_done),
        .ap_ready(c_ready), .rom_address(c_addr), .rom_ce(c_ce), .rom_q(c_q),
        .output_V_din(c_din), .output_V_full_n(full_n), .output_V_write(c_write));

    // ROM models with one cycle of read latency.
    always @(posedge clk) begin
        if (a_ce) a_q <= exp4[a_addr];
        if (b_ce) b_q <= exp4[b_addr];
        if (c_ce) c_q <= 16'd7;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; full_n = 1'b1;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; full_n = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        if (a_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", a_idle); end checks++;
        if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", a_done); end checks++;
        if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", a_ready); end checks++;
        if (a_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got=%b exp=0", a_ce); end checks++;
        if (a_addr !== 2'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", a_addr); end checks++;
        if (a_write !== 1'b0) begin errors++; $display("FAIL reset_write got=%b exp=0", a_write); end checks++;
        if (a_din !== 16'd0) begin errors++; $display("FAIL reset_din got=%0d exp=0", a_din); end checks++;
        if (c_idle !== 1'b1) begin errors++; $display("FAIL reset_c_idle got=%b exp=1", c_idle); end checks++;
        rst = 1'b0; start = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_run();
        logic exp_w, exp_d, exp_i, exp_ce;
        int k = 0;
        apply_reset();
        for (int c = 0; c <= 12; c++) begin
            start = (c == 0); full_n = 1'b1;
            @(negedge clk);
            exp_w  = (c >= 3) && (c <= 10);
            exp_d  = (c == 11);
            exp_i  = (c == 0) || (c == 12);
            exp_ce = (c >= 1) && (c <= 8);
            if (a_write !== exp_w) begin errors++; $display("FAIL run_write c=%0d got=%b exp=%b", c, a_write, exp_w); end checks++;
            if (exp_w) begin
                if (a_din !== exp4[k % 4]) begin errors++; $display("FAIL run_din c=%0d got=%0d exp=%0d", c, a_din, exp4[k % 4]); end checks++;
                k++;
            end
            if (a_done !== exp_d) begin errors++; $display("FAIL run_done c=%0d got=%b exp=%b", c, a_done, exp_d); end checks++;
            if (a_ready !== exp_d) begin errors++; $display("FAIL run_ready c=%0d got=%b exp=%b", c, a_ready, exp_d); end checks++;
            if (a_idle !== exp_i) begin errors++; $display("FAIL run_idle c=%0d got=%b exp=%b", c, a_idle, exp_i); end checks++;
            if (a_ce !== exp_ce) begin errors++; $display("FAIL run_ce c=%0d got=%b exp=%b", c, a_ce, exp_ce); end checks++;
            if (exp_ce || c == 12) begin
                if (a_addr !== 2'((c - 1) % 4) && c != 12 || (c == 12 && a_addr !== 2'd0)) begin
                    errors++; $display("FAIL run_addr c=%0d got=%0d", c, a_addr);
                end
                checks++;
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        logic exp_w;
        int k = 0;
        int outst = 0;
        apply_reset();
        for (int c = 0; c <= 16; c++) begin
            start = (c == 0); full_n = !((c >= 4) && (c <= 7));
            @(negedge clk);
            exp_w = (c == 3) || ((c >= 8) && (c <= 14));
            if (a_write !== exp_w) begin errors++; $display("FAIL stall_write c=%0d got=%b exp=%b", c, a_write, exp_w); end checks++;
            if (exp_w) begin
                if (a_din !== exp4[k % 4]) begin errors++; $display("FAIL stall_din c=%0d got=%0d exp=%0d", c, a_din, exp4[k % 4]); end checks++;
                k++;
            end
            if (c >= 4 && c <= 7) begin
                if (a_din !== 16'd20) begin errors++; $display("FAIL stall_hold c=%0d got=%0d exp=20", c, a_din); end checks++;
            end
            if (a_ce && (outst - int'(a_write)) >= 2) begin
                errors++; $display("FAIL stall_overflow c=%0d outstanding=%0d limit=1", c, outst - int'(a_write));
            end
            checks++;
            if (a_done !== (c == 15)) begin errors++; $display("FAIL stall_done c=%0d got=%b exp=%b", c, a_done, c == 15); end checks++;
            outst = outst + int'(a_ce) - int'(a_write);
            next_cycle();
        end
        if (k !== 8) begin errors++; $display("FAIL stall_count got=%0d exp=8", k); end checks++;
        if (a_idle !== 1'b1) begin errors++; $display("FAIL stall_idle got=%b exp=1", a_idle); end checks++;
    endtask

    task automatic test_toggle();
        logic exp_w;
        int k = 0;
        apply_reset();
        for (int c = 0; c <= 11; c++) begin
            start = (c == 0); full_n = (c % 2 == 1);
            @(negedge clk);
            exp_w = full_n && (c >= 3) && (k < 4);
            if (b_write !== exp_w) begin errors++; $display("FAIL toggle_write c=%0d got=%b exp=%b", c, b_write, exp_w); end checks++;
            if (exp_w) begin
                if (b_din !== exp4[k]) begin errors++; $display("FAIL toggle_din c=%0d got=%0d exp=%0d", c, b_din, exp4[k]); end checks++;
                k++;
            end
            if (b_done !== (c == 10)) begin errors++; $display("FAIL toggle_done c=%0d got=%b exp=%b", c, b_done, c == 10); end checks++;
            next_cycle();
        end
        if (b_idle !== 1'b1) begin errors++; $display("FAIL toggle_idle got=%b exp=1", b_idle); end checks++;
    endtask

    task automatic test_reset_mid();
        logic exp_w;
        int k = 0;
        apply_reset();
        for (int c = 0; c <= 6; c++) begin
            start = (c == 0); full_n = 1'b1; rst = (c == 6);
            next_cycle();
        end
        rst = 1'b0; start = 1'b1;
        @(negedge clk);
        if (a_write !== 1'b0) begin errors++; $display("FAIL rmid_write got=%b exp=0", a_write); end checks++;
        if (a_idle !== 1'b1) begin errors++; $display("FAIL rmid_idle got=%b exp=1", a_idle); end checks++;
        if (a_done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", a_done); end checks++;
        if (a_addr !== 2'd0) begin errors++; $display("FAIL rmid_addr got=%0d exp=0", a_addr); end checks++;
        if (a_din !== 16'd0) begin errors++; $display("FAIL rmid_din got=%0d exp=0", a_din); end checks++;
        next_cycle();
        for (int c = 8; c <= 20; c++) begin
            start = 1'b0;
            @(negedge clk);
            exp_w = (c >= 10) && (c <= 17);
            if (a_write !== exp_w) begin errors++; $display("FAIL rmid_rwrite c=%0d got=%b exp=%b", c, a_write, exp_w); end checks++;
            if (exp_w) begin
                if (a_din !== exp4[k % 4]) begin errors++; $display("FAIL rmid_rdin c=%0d got=%0d exp=%0d", c, a_din, exp4[k % 4]); end checks++;
                k++;
            end
            if (a_done !== (c == 18)) begin errors++; $display("FAIL rmid_rdone c=%0d got=%b exp=%b", c, a_done, c == 18); end checks++;
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic exp_w, exp_i;
        int k = 0;
        int m;
        apply_reset();
        for (int c = 0; c <= 25; c++) begin
            start = (c < 24); full_n = 1'b1;
            @(negedge clk);
            m     = c % 12;
            exp_w = (c < 24) && (m >= 3) && (m <= 10);
            exp_i = (c == 0) || (c == 12) || (c >= 24);
            if (a_write !== exp_w) begin errors++; $display("FAIL b2b_write c=%0d got=%b exp=%b", c, a_write, exp_w); end checks++;
            if (exp_w) begin
                if (a_din !== exp4[k % 4]) begin errors++; $display("FAIL b2b_din c=%0d got=%0d exp=%0d", c, a_din, exp4[k % 4]); end checks++;
                k++;
            end
            if (a_done !== (c == 11 || c == 23)) begin errors++; $display("FAIL b2b_done c=%0d got=%b", c, a_done); end checks++;
            if (a_idle !== exp_i) begin errors++; $display("FAIL b2b_idle c=%0d got=%b exp=%b", c, a_idle, exp_i); end checks++;
            next_cycle();
        end
    endtask

    task automatic test_single_word();
        logic exp_w, exp_ce;
        apply_reset();
        for (int c = 0; c <= 7; c++) begin
            start = (c == 0); full_n = 1'b1;
            @(negedge clk);
            exp_w  = (c >= 3) && (c <= 5);
            exp_ce = (c >= 1) && (c <= 3);
            if (c_write !== exp_w) begin errors++; $display("FAIL one_write c=%0d got=%b exp=%b", c, c_write, exp_w); end checks++;
            if (exp_w) begin
                if (c_din !== 16'd7) begin errors++; $display("FAIL one_din c=%0d got=%0d exp=7", c, c_din); end checks++;
            end
            if (c_ce !== exp_ce) begin errors++; $display("FAIL one_ce c=%0d got=%b exp=%b", c, c_ce, exp_ce); end checks++;
            if (c_addr !== 1'b0) begin errors++; $display("FAIL one_addr c=%0d got=%0d exp=0", c, c_addr); end checks++;
            if (c_done !== (c == 6)) begin errors++; $display("FAIL one_done c=%0d got=%b exp=%b", c, c_done, c == 6); end checks++;
            if (c_idle !== (c == 0 || c == 7)) begin errors++; $display("FAIL one_idle c=%0d got=%b", c, c_idle); end checks++;
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; full_n = 1'b1;
        test_reset();
        test_single_run();
        test_stall();
        test_toggle();
        test_reset_mid();
        test_back_to_back();
        test_single_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
